// File: rtl/auth_rx.sv
// UART 8N1 receiver feeding a "G"/"S" authorization handshake that gates platform power.
// The receiver samples each bit at mid-bit, timed from the synchronized falling edge of the start bit.
module auth_rx #(
  parameter int unsigned BAUD_CNT = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       pwr_up
);

  localparam int unsigned CNT_W  = 12;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned BYTE_W = 8;

  // Both loads are one less than the wait length, because the count includes the zero cycle.
  localparam logic [CNT_W-1:0]  FULL_LOAD = CNT_W'(BAUD_CNT - 1);
  localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(BAUD_CNT / 2 - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(BYTE_W - 1);
  localparam logic [BYTE_W-1:0] CHAR_G    = 8'h47;
  localparam logic [BYTE_W-1:0] CHAR_S    = 8'h53;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    AUTH_OFF,
    AUTH_PWR1,
    AUTH_PWR2
  } auth_state_t;

  logic              rx_meta;
  logic              rx_sync;
  logic              armed;
  logic [CNT_W-1:0]  baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BYTE_W-1:0] shift_reg;
  logic              baud_done;
  rx_state_t         rx_state;
  auth_state_t       auth_state;

  assign baud_done = (baud_cnt == '0);

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
    end
  end

  // Receiver FSM. A start is accepted only after the line has been seen high while in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= RX_IDLE;
      armed     <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rdy       <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          armed <= rx_sync;
          if (armed && !rx_sync) begin
            rx_state <= RX_START;
            baud_cnt <= HALF_LOAD;
            armed    <= 1'b0;
          end
        end
        RX_START: begin
          if (baud_done) begin
            if (!rx_sync) begin
              rx_state <= RX_DATA;
              baud_cnt <= FULL_LOAD;
              bit_cnt  <= '0;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (baud_done) begin
            shift_reg <= {rx_sync, shift_reg[BYTE_W-1:1]};
            baud_cnt  <= FULL_LOAD;
            bit_cnt   <= bit_cnt + BIT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              rx_state <= RX_STOP;
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (baud_done) begin
            if (rx_sync) begin
              rx_data <= shift_reg;
              rdy     <= 1'b1;
            end else begin
              frm_err <= 1'b1;
            end
            rx_state <= RX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end
        default: begin
          rx_state <= RX_IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

  // Authorization FSM. pwr_up is updated on the same edge as the state, one cycle after rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      auth_state <= AUTH_OFF;
      pwr_up     <= 1'b0;
    end else begin
      case (auth_state)
        AUTH_OFF: begin
          if (rdy && rx_data == CHAR_G) begin
            auth_state <= AUTH_PWR1;
            pwr_up     <= 1'b1;
          end
        end
        AUTH_PWR1: begin
          if (rdy && rx_data == CHAR_S) begin
            if (rider_off) begin
              auth_state <= AUTH_OFF;
              pwr_up     <= 1'b0;
            end else begin
              auth_state <= AUTH_PWR2;
              pwr_up     <= 1'b1;
            end
          end
        end
        AUTH_PWR2: begin
          // A fresh 'G' takes priority over the rider leaving.
          if (rdy && rx_data == CHAR_G) begin
            auth_state <= AUTH_PWR1;
            pwr_up     <= 1'b1;
          end else if (rider_off) begin
            auth_state <= AUTH_OFF;
            pwr_up     <= 1'b0;
          end
        end
        default: begin
          auth_state <= AUTH_OFF;
          pwr_up     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_auth_rx.sv
// Directed bench for auth_rx: serial frames with a cycle-level reference model and literal spot checks.
module tb_auth_rx;

  localparam int BAUD = 16;
  // Cycles from driving the start bit to the rdy/frm_err cycle:
  // 2 synchronizer edges, 1 edge to leave idle, a half bit, 8 data bits and the stop bit.
  localparam int LAT = 2 + 1 + BAUD / 2 + 9 * BAUD;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX;
  logic       rider_off;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       pwr_up;

  auth_rx #(.BAUD_CNT(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .rider_off (rider_off),
    .rx_data   (rx_data),
    .rdy       (rdy),
    .frm_err   (frm_err),
    .pwr_up    (pwr_up)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int rdy_seen = 0;
  int ferr_seen = 0;

  // Reference model state: one pending frame outcome, the last good byte, and the auth state (0=OFF, 1=PWR1, 2=PWR2).
  bit         chk_en = 1'b0;
  bit         ev_valid = 1'b0;
  int         ev_cyc = 0;
  bit         ev_err = 1'b0;
  logic [7:0] ev_byte = 8'h00;
  logic [7:0] m_data = 8'h00;
  int         m_auth = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, followed by advancing the model to the next cycle.
  always @(negedge clk) begin
    bit e_rdy;
    bit e_ferr;
    if (chk_en) begin
      e_rdy  = ev_valid && (cyc == ev_cyc) && !ev_err;
      e_ferr = ev_valid && (cyc == ev_cyc) && ev_err;
      if (e_rdy) m_data = ev_byte;
      chk("rdy", 32'(rdy), 32'(e_rdy));
      chk("frm_err", 32'(frm_err), 32'(e_ferr));
      chk("rx_data", 32'(rx_data), 32'(m_data));
      chk("pwr_up", 32'(pwr_up), 32'(m_auth != 0));
      if (rdy) rdy_seen++;
      if (frm_err) ferr_seen++;
      if (rst) begin
        m_auth   = 0;
        m_data   = 8'h00;
        ev_valid = 1'b0;
      end else begin
        case (m_auth)
          0: if (e_rdy && ev_byte == 8'h47) m_auth = 1;
          1: if (e_rdy && ev_byte == 8'h53) m_auth = rider_off ? 0 : 2;
          default: begin
            if (e_rdy && ev_byte == 8'h47) m_auth = 1;
            else if (rider_off) m_auth = 0;
          end
        endcase
        if (ev_valid && cyc == ev_cyc) ev_valid = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one 8N1 frame. abort_after >= 0 hits reset halfway through data bit abort_after.
  task automatic send(input logic [7:0] b, input bit stop_bit, input int abort_after);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    @(posedge clk);
    #1;
    if (abort_after < 0) begin
      ev_cyc   = cyc + LAT;
      ev_err   = !stop_bit;
      ev_byte  = b;
      ev_valid = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      RX = frame[i];
      if (abort_after >= 0 && i == abort_after + 1) begin
        idle(BAUD / 2);
        rst = 1'b1;
        RX  = 1'b1;
        idle(2);
        chk("abort_rx_data", 32'(rx_data), 32'h00);
        chk("abort_rdy", 32'(rdy), 32'h0);
        chk("abort_frm_err", 32'(frm_err), 32'h0);
        chk("abort_pwr_up", 32'(pwr_up), 32'h0);
        rst = 1'b0;
        idle(20);
        return;
      end
      idle(BAUD);
    end
    RX = 1'b1;
    idle(20);
  endtask

  initial begin
    rst = 1'b1;
    RX = 1'b1;
    rider_off = 1'b0;
    idle(2);
    chk_en = 1'b1;
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_rdy", 32'(rdy), 32'h0);
    chk("reset_frm_err", 32'(frm_err), 32'h0);
    chk("reset_pwr_up", 32'(pwr_up), 32'h0);
    rst = 1'b0;
    idle(10);

    // 'G' from OFF authorizes.
    send(8'h47, 1'b1, -1);
    chk("G_rx_data", 32'(rx_data), 32'h47);
    chk("G_pwr_up", 32'(pwr_up), 32'h1);
    chk("G_rdy_count", 32'(rdy_seen), 32'd1);

    // 'S' with rider present -> PWR2, then rider leaves.
    send(8'h53, 1'b1, -1);
    chk("S_pwr2_pwr_up", 32'(pwr_up), 32'h1);
    rider_off = 1'b1;
    idle(1);
    chk("rider_off_pwr_up", 32'(pwr_up), 32'h0);
    rider_off = 1'b0;
    idle(5);

    // 'S' with no rider from PWR1 -> OFF; a second 'S' in OFF does nothing.
    send(8'h47, 1'b1, -1);
    chk("G2_pwr_up", 32'(pwr_up), 32'h1);
    rider_off = 1'b1;
    send(8'h53, 1'b1, -1);
    chk("S_norider_pwr_up", 32'(pwr_up), 32'h0);
    send(8'h53, 1'b1, -1);
    chk("S_off_pwr_up", 32'(pwr_up), 32'h0);
    chk("S_off_rx_data", 32'(rx_data), 32'h53);
    rider_off = 1'b0;
    idle(3);

    // Framing error leaves data and authorization alone.
    send(8'h47, 1'b1, -1);
    send(8'hA5, 1'b0, -1);
    chk("ferr_count", 32'(ferr_seen), 32'd1);
    chk("ferr_rdy_count", 32'(rdy_seen), 32'd6);
    chk("ferr_rx_data", 32'(rx_data), 32'h47);
    chk("ferr_pwr_up", 32'(pwr_up), 32'h1);

    // Short low glitch is rejected as a false start.
    send(8'hC3, 1'b1, -1);
    @(posedge clk);
    #1;
    RX = 1'b0;
    idle(4);
    RX = 1'b1;
    idle(30);
    chk("glitch_rdy_count", 32'(rdy_seen), 32'd7);
    chk("glitch_ferr_count", 32'(ferr_seen), 32'd1);
    send(8'h47, 1'b1, -1);
    chk("post_glitch_rx_data", 32'(rx_data), 32'h47);
    chk("post_glitch_rdy_count", 32'(rdy_seen), 32'd8);

    // Reset in the middle of a frame, then a clean frame is received.
    send(8'h47, 1'b1, 3);
    chk("abort_rdy_count", 32'(rdy_seen), 32'd8);
    send(8'h47, 1'b1, -1);
    chk("after_rst_rx_data", 32'(rx_data), 32'h47);
    chk("after_rst_pwr_up", 32'(pwr_up), 32'h1);
    chk("final_rdy_count", 32'(rdy_seen), 32'd9);
    chk("final_ferr_count", 32'(ferr_seen), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/auth_rx.md
AUTH_RX -- requirements
Module: auth_rx

Interface
REQ-001 SHALL have parameter BAUD_CNT, default 2604, clock cycles per bit (50 MHz / 19200 baud); legal range 8..4095.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port RX  input  1  asynchronous UART serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port rider_off  input  1  synchronous; high when no rider load is detected.
REQ-006 SHALL have port rx_data  output  8  last correctly framed byte received.
REQ-007 SHALL have port rdy  output  1  one-cycle pulse when rx_data is updated.
REQ-008 SHALL have port frm_err  output  1  one-cycle pulse when a byte's stop bit samples low.
REQ-009 SHALL have port pwr_up  output  1  registered; high while the platform is authorized.

Function -- receiver
REQ-010 SHALL pass RX through two flops, reset value 1, before any use; all RX references below mean the synchronized value.
REQ-011 SHALL implement receiver states IDLE, START, DATA, STOP.
REQ-012 IDLE: on a synchronized 1->0 transition, SHALL enter START and load the baud counter to count BAUD_CNT/2 cycles (integer division).
REQ-013 START: at half-bit expiry, RX=0 -> DATA with the counter reloaded to BAUD_CNT; RX=1 -> IDLE (false start, no rdy, no frm_err).
REQ-014 DATA: SHALL sample RX at each BAUD_CNT expiry into a right-shifting register (first bit lands in bit 0 after 8 shifts); after the 8th sample, -> STOP.
REQ-015 STOP: at BAUD_CNT expiry, RX=1 -> load rx_data, pulse rdy for exactly one cycle, -> IDLE; RX=0 -> pulse frm_err for one cycle, rx_data unchanged, -> IDLE.
REQ-016 SHALL require RX high for at least one cycle in IDLE before a new start is accepted; a line held low after a frame error SHALL NOT retrigger.
REQ-017 Bit counter SHALL be 4 bits; baud counter 12 bits; neither shall wrap during a frame.

Function -- authorization
REQ-018 SHALL implement states OFF, PWR1, PWR2; pwr_up=1 in PWR1 and PWR2, 0 in OFF.
REQ-019 OFF: rdy with rx_data=0x47 ('G') -> PWR1; all other bytes ignored.
REQ-020 PWR1: rdy with 0x53 ('S') -> OFF if rider_off=1 that cycle, else -> PWR2; other bytes ignored.
REQ-021 PWR2: rider_off=1 -> OFF; rdy with 0x47 -> PWR1; when rider_off=1 and 'G' coincide, 'G' wins (-> PWR1).
REQ-022 State transitions SHALL occur on the clock edge after the rdy cycle; pwr_up SHALL change on that same edge (1-cycle latency from rdy).
REQ-023 frm_err SHALL NOT affect the authorization FSM.

Reset
REQ-024 rst SHALL force, on the next rising edge: receiver IDLE, counters 0, rx_data=0x00, rdy=0, frm_err=0, pwr_up=0, auth FSM OFF, sync flops 1.
REQ-025 rst asserted mid-frame SHALL abort the frame with no rdy or frm_err; the first start edge after rst deasserts SHALL be received normally.

Verification (BAUD_CNT=16)
REQ-026 Send 0x47 (start, bits LSB first, stop=1) -> rdy pulses once at ~9.5 bit times, rx_data=0x47, pwr_up=1 one cycle later.
REQ-027 From PWR1 with rider_off=0, send 0x53 -> pwr_up stays 1 (PWR2); then raise rider_off -> pwr_up=0 next cycle.
REQ-028 From PWR1 with rider_off=1, send 0x53 -> pwr_up=0 one cycle after rdy; then send 0x53 in OFF -> no change.
REQ-029 Send 0xA5 with stop bit=0 -> frm_err pulses once, no rdy, rx_data keeps its prior value, pwr_up unchanged.
REQ-030 Low glitch of 4 cycles on idle RX -> no rdy, no frm_err, receiver back in IDLE; next 0x47 is received correctly.
REQ-031 Assert rst during DATA of a 0x47 frame -> all outputs 0; after release, a full 0x47 -> pwr_up=1.
